// File: rtl/core_multicycle.sv
// core_multicycle: single-clock multicycle RV32I core; instruction and data memories sit behind req/ack handshakes.
// Defining CORE_STATUS_TX_EN builds the ASCII status formatter on tx_word; otherwise tx_word is tied to zero.
module core_multicycle #(
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
    parameter logic [31:0] PASS_ADDR    = 32'h0000_0000,
    parameter logic [31:0] FAIL_ADDR    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [2:0]  dmem_fn3,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] pc_out,
    output logic [1:0]  status,
    output logic [5:0]  leds,
    output logic [31:0] tx_word
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR} state_e;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [31:0] alu_q, alu_d, mdr_q, mdr_d, tmo_q, tmo_d;
    logic        taken_q, taken_d, ireq_q, ireq_d, dreq_q, dreq_d;
    logic [1:0]  status_q, status_d;
    logic [5:0]  leds_q, leds_d;
    logic [31:0] rf [32];

    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, alu_res, pc_plus4, ld_sh, ld_val, wb_data;
    logic        br_taken, rf_wen, rf_we;

    assign opc     = ir_q[6:0];
    assign rd      = ir_q[11:7];
    assign f3      = ir_q[14:12];
    assign rs1     = ir_q[19:15];
    assign rs2     = ir_q[24:20];
    assign imm_i   = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b   = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u   = {ir_q[31:12], 12'h000};
    assign imm_j   = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign rs1_val = (rs1 == 5'd0) ? 32'h0 : rf[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'h0 : rf[rs2];
    assign pc_plus4 = pc_q + 32'd4;

    function automatic logic [31:0] alu_op(input logic [31:0] x, input logic [31:0] y,
                                           input logic [2:0] fn, input logic alt);
        case (fn)
            3'd0:    return alt ? x - y : x + y;
            3'd1:    return x << y[4:0];
            3'd2:    return {31'h0, $signed(x) < $signed(y)};
            3'd3:    return {31'h0, x < y};
            3'd4:    return x ^ y;
            3'd5:    return alt ? $unsigned($signed(x) >>> y[4:0]) : x >> y[4:0];
            3'd6:    return x | y;
            default: return x & y;
        endcase
    endfunction

    // Branch/jump targets come out of the same adder path so WB only picks alu_q.
    always_comb begin
        alu_res = 32'h0;
        case (opc)
            OP_LUI:   alu_res = imm_u;
            OP_AUIPC: alu_res = pc_q + imm_u;
            OP_JAL:   alu_res = pc_q + imm_j;
            OP_JALR:  alu_res = a_q + imm_i;
            OP_BR:    alu_res = pc_q + imm_b;
            OP_LD:    alu_res = a_q + imm_i;
            OP_ST:    alu_res = a_q + imm_s;
            OP_IMM:   alu_res = alu_op(a_q, imm_i, f3, (f3 == 3'd5) && ir_q[30]);
            OP_REG:   alu_res = alu_op(a_q, b_q, f3, ir_q[30]);
            default:  alu_res = 32'h0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (f3)
            3'd0:    br_taken = (a_q == b_q);
            3'd1:    br_taken = (a_q != b_q);
            3'd4:    br_taken = ($signed(a_q) < $signed(b_q));
            3'd5:    br_taken = ($signed(a_q) >= $signed(b_q));
            3'd6:    br_taken = (a_q < b_q);
            3'd7:    br_taken = (a_q >= b_q);
            default: br_taken = 1'b0;
        endcase
    end

    // Load data arrives as the full aligned word; pick the addressed lane.
    assign ld_sh = mdr_q >> {alu_q[1:0], 3'b000};
    always_comb begin
        ld_val = ld_sh;
        case (f3)
            3'd0:    ld_val = {{24{ld_sh[7]}}, ld_sh[7:0]};
            3'd1:    ld_val = {{16{ld_sh[15]}}, ld_sh[15:0]};
            3'd4:    ld_val = {24'h0, ld_sh[7:0]};
            3'd5:    ld_val = {16'h0, ld_sh[15:0]};
            default: ld_val = ld_sh;
        endcase
    end

    assign rf_wen  = (opc == OP_LUI) || (opc == OP_AUIPC) || (opc == OP_JAL) || (opc == OP_JALR) ||
                     (opc == OP_LD) || (opc == OP_IMM) || (opc == OP_REG);
    assign wb_data = ((opc == OP_JAL) || (opc == OP_JALR)) ? pc_plus4 :
                     (opc == OP_LD) ? ld_val : alu_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        taken_d  = taken_q;
        status_d = status_q;
        rf_we    = 1'b0;
        tmo_d    = ((ireq_q && !imem_ack) || (dreq_q && !dmem_ack)) ? tmo_q + 32'd1 : 32'd0;
        case (state_q)
            FETCH: if (ireq_q && imem_ack) begin
                ir_d    = imem_rdata;
                state_d = DECODE;
            end
            DECODE: begin
                a_d = rs1_val;
                b_d = rs2_val;
                if (FAIL_ADDR != 32'h0 && pc_q == FAIL_ADDR) begin
                    state_d  = HALT;
                    status_d = 2'b10;
                end else if (PASS_ADDR != 32'h0 && pc_q == PASS_ADDR) begin
                    state_d  = HALT;
                    status_d = 2'b01;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_d   = alu_res;
                taken_d = br_taken;
                state_d = ((opc == OP_LD) || (opc == OP_ST)) ? MEM : WB;
            end
            MEM: if (dreq_q && dmem_ack) begin
                mdr_d   = dmem_rdata;
                state_d = WB;
            end
            WB: begin
                rf_we = rf_wen && (rd != 5'd0);
                if (((opc == OP_BR) && taken_q) || (opc == OP_JAL)) pc_d = alu_q;
                else if (opc == OP_JALR)                           pc_d = {alu_q[31:1], 1'b0};
                else                                                pc_d = pc_plus4;
                state_d = FETCH;
            end
            default: ;
        endcase
        if (MEM_TIMEOUT != 0 && tmo_d == MEM_TIMEOUT) begin
            state_d  = ERROR;
            status_d = 2'b11;
        end
        ireq_d = (state_d == FETCH);
        dreq_d = (state_d == MEM);
        case (state_d)
            HALT:    leds_d = (status_d == 2'b10) ? 6'b111001 : 6'b101011;
            ERROR:   leds_d = 6'b111111;
            default: leds_d = {pc_d[6:2], 1'b0};
        endcase
    end

    // Requests are registered so reset drops them on the next edge and stray acks find no req.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_VECTOR;
            ir_q     <= 32'h0;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            alu_q    <= 32'h0;
            mdr_q    <= 32'h0;
            taken_q  <= 1'b0;
            ireq_q   <= 1'b0;
            dreq_q   <= 1'b0;
            status_q <= 2'b00;
            leds_q   <= 6'h0;
            tmo_q    <= 32'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            alu_q    <= alu_d;
            mdr_q    <= mdr_d;
            taken_q  <= taken_d;
            ireq_q   <= ireq_d;
            dreq_q   <= dreq_d;
            status_q <= status_d;
            leds_q   <= leds_d;
            tmo_q    <= tmo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && rf_we) rf[rd] <= wb_data;
    end

    assign imem_req   = ireq_q;
    assign imem_addr  = pc_q;
    assign dmem_req   = dreq_q;
    assign dmem_we    = (opc == OP_ST);
    assign dmem_addr  = alu_q;
    assign dmem_wdata = b_q;
    assign dmem_fn3   = f3;
    assign pc_out     = pc_q;
    assign status     = status_q;
    assign leds       = leds_q;

`ifdef CORE_STATUS_TX_EN
    logic [31:0] tx_q, tx_d;

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    always_comb begin
        tx_d = tx_q;
        if (state_d != state_q) begin
            case (state_d)
                DECODE:  tx_d = {hexc(pc_q[15:12]), hexc(pc_q[11:8]), hexc(pc_q[7:4]), hexc(pc_q[3:0])};
                HALT:    tx_d = (status_d == 2'b10) ? "fail" : "pass";
                ERROR:   tx_d = "err!";
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) tx_q <= 32'h0;
        else        tx_q <= tx_d;
    end

    assign tx_word = tx_q;
`else
    assign tx_word = 32'h0;
`endif

endmodule
